// File: rtl/uart_command_system.sv
// UART command processor: received bytes drive a command FSM over a 16x8 register file
// and a 16-bit ALU; read and ALU results are returned as UART frames.
module uart_command_system #(
  parameter int unsigned DATA_WIDTH               = 8,
  parameter int unsigned REGISTER_FILE_DEPTH      = 16,
  parameter int unsigned SYNCHRONIZER_STAGE_COUNT = 2,
  parameter int unsigned CLKS_PER_BIT             = 8
) (
  input  logic reference_clk,
  input  logic reset,
  input  logic serial_data_in,
  output logic serial_data_out,
  output logic parity_error,
  output logic frame_error,
  output logic transmitter_busy
);

  localparam int unsigned ADDR_W  = $clog2(REGISTER_FILE_DEPTH);
  localparam int unsigned RES_W   = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned FRAME_W = DATA_WIDTH + 3;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_CALC  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_REDO  = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN, SEND_LO, SEND_HI
  } state_t;

  // Unsigned 8-bit operands, 16-bit result.
  function automatic logic [RES_W-1:0] alu(input logic [DATA_WIDTH-1:0] a,
                                           input logic [DATA_WIDTH-1:0] b,
                                           input logic [3:0] fn);
    logic [RES_W-1:0] ax;
    logic [RES_W-1:0] bx;
    logic [DATA_WIDTH-1:0] zero;
    ax   = {{DATA_WIDTH{1'b0}}, a};
    bx   = {{DATA_WIDTH{1'b0}}, b};
    zero = '0;
    case (fn)
      4'h0:    return ax + bx;
      4'h1:    return ax - bx;
      4'h2:    return ax * bx;
      4'h3:    return (b == zero) ? '0 : {zero, a / b};
      4'h4:    return {zero, a & b};
      4'h5:    return {zero, a | b};
      4'h6:    return {zero, ~(a & b)};
      4'h7:    return {zero, ~(a | b)};
      4'h8:    return {zero, a ^ b};
      4'h9:    return {zero, ~(a ^ b)};
      4'hA:    return {{(RES_W-1){1'b0}}, a == b};
      4'hB:    return {{(RES_W-1){1'b0}}, a > b};
      4'hC:    return {{(RES_W-1){1'b0}}, a < b};
      4'hD:    return {zero, a >> 1};
      4'hE:    return ax << 1;
      default: return '0;
    endcase
  endfunction

  logic [SYNCHRONIZER_STAGE_COUNT-1:0] sync_q;
  logic rx_line;

  always_ff @(posedge reference_clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNCHRONIZER_STAGE_COUNT-2:0], serial_data_in};
  end
  assign rx_line = sync_q[SYNCHRONIZER_STAGE_COUNT-1];

  // Receiver: mid-bit sampling, data and parity shifted in LSB first.
  logic                  rx_prev, rx_active, rx_good, rx_bad;
  logic [CNT_W-1:0]      rx_cnt;
  logic [BIT_W-1:0]      rx_bit;
  logic [DATA_WIDTH:0]   rx_shift;
  logic [DATA_WIDTH-1:0] rx_byte;

  always_ff @(posedge reference_clk) begin
    if (reset) begin
      rx_prev      <= 1'b1;
      rx_active    <= 1'b0;
      rx_good      <= 1'b0;
      rx_bad       <= 1'b0;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_prev <= rx_line;
      rx_good <= 1'b0;
      rx_bad  <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_line) begin
          rx_active <= 1'b1;
          rx_cnt    <= CNT_W'(CLKS_PER_BIT / 2 - 1);
          rx_bit    <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CNT_W'(1);
      end else if (rx_bit == '0) begin
        rx_active <= !rx_line;  // a start bit that has gone high was a glitch
        rx_bit    <= BIT_W'(1);
        rx_cnt    <= CNT_W'(CLKS_PER_BIT - 1);
      end else if (rx_bit == BIT_W'(FRAME_W - 1)) begin
        rx_active    <= 1'b0;
        parity_error <= ^rx_shift;
        frame_error  <= !rx_line;
        rx_byte      <= rx_shift[DATA_WIDTH-1:0];
        rx_good      <= !(^rx_shift) && rx_line;
        rx_bad       <= (^rx_shift) || !rx_line;
      end else begin
        rx_shift <= {rx_line, rx_shift[DATA_WIDTH:1]};
        rx_bit   <= rx_bit + BIT_W'(1);
        rx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
      end
    end
  end

  // Transmitter: a full frame, then one idle bit period before the next load.
  logic                  tx_start_c, tx_ready_c;
  logic [DATA_WIDTH-1:0] tx_byte_c;
  logic [FRAME_W-1:0]    tx_shift;
  logic [CNT_W-1:0]      tx_cnt, tx_gap;
  logic [BIT_W-1:0]      tx_bit;

  assign tx_ready_c = !transmitter_busy && (tx_gap == '0);

  always_ff @(posedge reference_clk) begin
    if (reset) begin
      serial_data_out  <= 1'b1;
      transmitter_busy <= 1'b0;
      tx_shift         <= '1;
      tx_cnt           <= '0;
      tx_gap           <= '0;
      tx_bit           <= '0;
    end else if (!transmitter_busy) begin
      if (tx_gap != '0) begin
        tx_gap <= tx_gap - CNT_W'(1);
      end else if (tx_start_c) begin
        tx_shift         <= {1'b1, ^tx_byte_c, tx_byte_c, 1'b0};
        serial_data_out  <= 1'b0;
        transmitter_busy <= 1'b1;
        tx_cnt           <= CNT_W'(CLKS_PER_BIT - 1);
        tx_bit           <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CNT_W'(1);
    end else if (tx_bit == BIT_W'(FRAME_W - 1)) begin
      transmitter_busy <= 1'b0;
      serial_data_out  <= 1'b1;
      tx_gap           <= CNT_W'(CLKS_PER_BIT - 1);
    end else begin
      tx_shift        <= {1'b1, tx_shift[FRAME_W-1:1]};
      serial_data_out <= tx_shift[1];
      tx_bit          <= tx_bit + BIT_W'(1);
      tx_cnt          <= CNT_W'(CLKS_PER_BIT - 1);
    end
  end

  // Command FSM and its datapath.
  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] regs [REGISTER_FILE_DEPTH];
  logic [ADDR_W-1:0]     addr_q, reg_addr_c;
  logic [DATA_WIDTH-1:0] reg_data_c;
  logic [RES_W-1:0]      result_q, result_c;
  logic                  single_q, single_c;
  logic                  accept_c, reg_we_c, addr_we_c, result_we_c;

  assign accept_c = rx_good && !transmitter_busy;

  always_ff @(posedge reference_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_c) begin
        if      (rx_byte == OP_WRITE) state_next = WR_ADDR;
        else if (rx_byte == OP_READ)  state_next = RD_ADDR;
        else if (rx_byte == OP_CALC)  state_next = OP_A;
        else if (rx_byte == OP_REDO)  state_next = ALU_FN;
      end
      WR_ADDR: if (accept_c) state_next = WR_DATA;
      WR_DATA: if (accept_c) state_next = IDLE;
      RD_ADDR: if (accept_c) state_next = SEND_LO;
      OP_A:    if (accept_c) state_next = OP_B;
      OP_B:    if (accept_c) state_next = ALU_FN;
      ALU_FN:  if (accept_c) state_next = SEND_LO;
      SEND_LO: if (tx_ready_c) state_next = single_q ? IDLE : SEND_HI;
      SEND_HI: if (tx_ready_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rx_bad && state != SEND_LO && state != SEND_HI) state_next = IDLE;
  end

  always_comb begin
    reg_we_c    = 1'b0;
    reg_addr_c  = addr_q;
    reg_data_c  = rx_byte;
    addr_we_c   = 1'b0;
    result_we_c = 1'b0;
    result_c    = '0;
    single_c    = 1'b0;
    tx_start_c  = 1'b0;
    tx_byte_c   = result_q[DATA_WIDTH-1:0];
    case (state)
      WR_ADDR: addr_we_c = accept_c;
      WR_DATA: reg_we_c  = accept_c;
      RD_ADDR: begin
        result_we_c = accept_c;
        single_c    = 1'b1;
        result_c    = {{DATA_WIDTH{1'b0}}, regs[rx_byte[ADDR_W-1:0]]};
      end
      OP_A: begin
        reg_we_c   = accept_c;
        reg_addr_c = ADDR_W'(0);
      end
      OP_B: begin
        reg_we_c   = accept_c;
        reg_addr_c = ADDR_W'(1);
      end
      ALU_FN: begin
        result_we_c = accept_c;
        result_c    = alu(regs[0], regs[1], rx_byte[3:0]);
      end
      SEND_LO: tx_start_c = tx_ready_c;
      SEND_HI: begin
        tx_start_c = tx_ready_c;
        tx_byte_c  = result_q[RES_W-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge reference_clk) begin
    if (reset) begin
      for (int i = 0; i < REGISTER_FILE_DEPTH; i++) regs[i] <= '0;
      addr_q   <= '0;
      result_q <= '0;
      single_q <= 1'b0;
    end else begin
      if (reg_we_c)  regs[reg_addr_c] <= reg_data_c;
      if (addr_we_c) addr_q <= rx_byte[ADDR_W-1:0];
      if (result_we_c) begin
        result_q <= result_c;
        single_q <= single_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_command_system.sv
// Bench for uart_command_system: drives UART command frames and checks returned frames
// against an expected-byte scoreboard, plus status flags and reset behaviour.
`timescale 1ns/1ps
module tb_uart_command_system;

  localparam int unsigned CPB = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic tx, perr, ferr, busy;

  always #5 clk = ~clk;

  uart_command_system #(
    .DATA_WIDTH(8), .REGISTER_FILE_DEPTH(16),
    .SYNCHRONIZER_STAGE_COUNT(2), .CLKS_PER_BIT(CPB)
  ) dut (
    .reference_clk(clk), .reset(reset), .serial_data_in(rx),
    .serial_data_out(tx), .parity_error(perr), .frame_error(ferr),
    .transmitter_busy(busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  fn;
    logic [15:0] res;
  } alu_vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         busy_rises = 0;
  logic       busy_d = 1'b0;

  always @(posedge clk) begin
    busy_d <= busy;
    if (busy && !busy_d) busy_rises <= busy_rises + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
    logic [10:0] f;
    f = {stop_bit, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 4000), 1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  // TX line decoder: samples each bit mid-period and pops the scoreboard.
  initial begin : tx_monitor
    logic [7:0] d;
    logic [7:0] e;
    logic       p;
    logic       s;
    int         idle_run;
    int         frames;
    idle_run = 0;
    frames   = 0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        if (frames > 0) check("tx_idle_gap", 32'(idle_run >= CPB), 1);
        repeat (CPB / 2 - 1) @(negedge clk);
        check("tx_start_busy", 32'({tx, busy}), 32'h1);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        p = tx;
        repeat (CPB) @(negedge clk);
        s = tx;
        check("tx_stop_busy", 32'({s, busy}), 32'h3);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no frame", d);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(d), 32'(e));
          check("tx_parity", 32'(p), 32'(^e));
        end
        frames++;
        idle_run = 0;
      end else if (busy == 1'b0) begin
        idle_run++;
      end else begin
        idle_run = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    alu_vec_t vecs[19];
    int       rises0;
    vecs = '{
      '{8'h10, 8'h20, 8'h00, 16'h0030}, '{8'h05, 8'h07, 8'h01, 16'hFFFE},
      '{8'hFF, 8'hFF, 8'h02, 16'hFE01}, '{8'h64, 8'h07, 8'h03, 16'h000E},
      '{8'h64, 8'h00, 8'h03, 16'h0000}, '{8'hF0, 8'h3C, 8'h04, 16'h0030},
      '{8'hF0, 8'h0F, 8'h05, 16'h00FF}, '{8'hF0, 8'h3C, 8'h06, 16'h00CF},
      '{8'hF0, 8'h3C, 8'h07, 16'h0003}, '{8'hAA, 8'h0F, 8'h08, 16'h00A5},
      '{8'hAA, 8'h0F, 8'h09, 16'h005A}, '{8'h33, 8'h33, 8'h0A, 16'h0001},
      '{8'h34, 8'h33, 8'h0B, 16'h0001}, '{8'h33, 8'h34, 8'h0B, 16'h0000},
      '{8'h34, 8'h33, 8'h0C, 16'h0000}, '{8'h33, 8'h34, 8'h0C, 16'h0001},
      '{8'h81, 8'h00, 8'h0D, 16'h0040}, '{8'h81, 8'h00, 8'h0E, 16'h0102},
      '{8'h12, 8'h34, 8'h0F, 16'h0000}
    };

    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_tx", 32'(tx), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_perr", 32'(perr), 0);
    check("reset_ferr", 32'(ferr), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write then read back one register.
    rises0 = busy_rises;
    send(8'hAA); send(8'h05); send(8'h3C);
    drain("write");
    send(8'hBB);
    exp_q.push_back(8'h3C);
    send(8'h05);
    drain("read");
    check("read_busy_pulses", busy_rises - rises0, 1);

    // ALU with operands, then operand registers read back, then ALU on stored operands.
    rises0 = busy_rises;
    send(8'hCC); send(8'h10); send(8'h20);
    exp_q.push_back(8'h30); exp_q.push_back(8'h00);
    send(8'h00);
    drain("calc");
    check("calc_busy_pulses", busy_rises - rises0, 2);
    send(8'hBB); exp_q.push_back(8'h10); send(8'h00); drain("read_reg0");
    send(8'hBB); exp_q.push_back(8'h20); send(8'h01); drain("read_reg1");
    send(8'hDD); exp_q.push_back(8'h00); exp_q.push_back(8'h02); send(8'h02); drain("redo");

    // Every ALU function through the full command path.
    for (int i = 0; i < 19; i++) begin
      send(8'hCC); send(vecs[i].a); send(vecs[i].b);
      exp_q.push_back(vecs[i].res[7:0]);
      exp_q.push_back(vecs[i].res[15:8]);
      send(vecs[i].fn);
      drain("alu_vec");
    end
    send(8'hDD); exp_q.push_back(8'hDE); exp_q.push_back(8'hFF); send(8'h01); drain("redo_sub");

    // Bad parity on a write opcode: flagged, discarded, following bytes ignored.
    send_frame(8'hAA, 1'b1, 1'b1);
    check("perr_set", 32'({perr, ferr}), 32'h2);
    send(8'h07);
    check("perr_cleared", 32'(perr), 0);
    send(8'h99);
    send(8'hBB); exp_q.push_back(8'h00); send(8'h07); drain("perr_no_write");

    // Missing stop bit on a read opcode: flagged, no response.
    rises0 = busy_rises;
    send_frame(8'hBB, 1'b0, 1'b0);
    check("ferr_set", 32'({perr, ferr}), 32'h1);
    send(8'h05);
    drain("ferr");
    check("ferr_no_response", busy_rises - rises0, 0);
    check("ferr_cleared", 32'(ferr), 0);

    // Address byte uses only its low four bits.
    send(8'hAA); send(8'hF3); send(8'h77);
    send(8'hBB); exp_q.push_back(8'h77); send(8'h03); drain("addr_wrap");

    // Reset during data bits of a frame.
    send_frame(8'hAA, 1'b1, 1'b1);
    check("perr_before_reset", 32'(perr), 1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_outputs", 32'({tx, busy, perr, ferr}), 32'h8);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(8'hBB); exp_q.push_back(8'h00); send(8'h05); drain("after_reset");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
